// File: rtl/subneg_mem_responder.sv
// Memory-bus target for the SUBNEG processor: address latch, byte SRAM and
// output latch driven by the processor strobes, plus a side preload port.
module subneg_mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic       latch_clk,
    input  logic       mem_oe_n,
    input  logic       mem_we_n,
    input  logic       out_latch_clk,
    output logic [7:0] out_value,
    output logic       out_strobe,
    output logic       bus_conflict,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address wraps modulo DEPTH by keeping only the low bits.
    function automatic logic [ADDR_W-1:0] mem_index(input logic [7:0] addr);
        return addr[ADDR_W-1:0];
    endfunction

    logic [7:0]        mem_r [DEPTH];
    logic [7:0]        addr_r;
    logic              latch_clk_r;
    logic              out_latch_clk_r;
    logic [7:0]        out_value_r;
    logic              out_strobe_r;
    logic              bus_conflict_r;

    logic [ADDR_W-1:0] addr_idx_s;
    logic [ADDR_W-1:0] load_idx_s;
    logic              latch_rise_s;
    logic              out_rise_s;
    logic              conflict_s;
    logic              bus_wr_s;

    // Edge detection, index decode and bus-write qualification.
    always_comb begin
        addr_idx_s   = mem_index(addr_r);
        load_idx_s   = mem_index(load_addr);
        latch_rise_s = latch_clk & ~latch_clk_r;
        out_rise_s   = out_latch_clk & ~out_latch_clk_r;
        conflict_s   = ~mem_oe_n & ~mem_we_n;
        bus_wr_s     = 1'b0;
        if (reset) begin
            bus_wr_s = 1'b0;
        end else if (load_en && (load_idx_s == addr_idx_s)) begin
            // Preload owns the location this cycle; the bus write is dropped.
            bus_wr_s = 1'b0;
        end else begin
            bus_wr_s = ~mem_we_n & mem_oe_n;
        end
    end

    // Read data is asynchronous so it is valid in the cycle OE falls.
    assign bus_out      = mem_r[addr_idx_s];
    assign bus_oe       = ~mem_oe_n;
    assign out_value    = out_value_r;
    assign out_strobe   = out_strobe_r;
    assign bus_conflict = bus_conflict_r;

    // SRAM array: preload and bus writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_r[load_idx_s] <= load_data;
        end
        if (bus_wr_s) begin
            mem_r[addr_idx_s] <= bus_in;
        end
    end

    // Strobe history, address latch, output latch and sticky conflict flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r          <= 8'h00;
            latch_clk_r     <= 1'b0;
            out_latch_clk_r <= 1'b0;
            out_value_r     <= 8'h00;
            out_strobe_r    <= 1'b0;
            bus_conflict_r  <= 1'b0;
        end else begin
            latch_clk_r     <= latch_clk;
            out_latch_clk_r <= out_latch_clk;
            out_strobe_r    <= out_rise_s;
            if (latch_rise_s) begin
                addr_r <= bus_in;
            end else begin
                addr_r <= addr_r;
            end
            if (out_rise_s) begin
                out_value_r <= bus_in;
            end else begin
                out_value_r <= out_value_r;
            end
            bus_conflict_r <= bus_conflict_r | conflict_s;
        end
    end

endmodule

// File: tb/tb_subneg_mem_responder.sv
// Directed self-checking bench for subneg_mem_responder (DEPTH 256 and 16).
module tb_subneg_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_in;
    logic       latch_clk, mem_oe_n, mem_we_n, out_latch_clk;
    logic       load_en;
    logic [7:0] load_addr, load_data;

    logic [7:0] bus_out,  out_value;
    logic       bus_oe,   out_strobe,  bus_conflict;
    logic [7:0] bus_out16, out_value16;
    logic       bus_oe16, out_strobe16, bus_conflict16;

    int pass_cnt  = 0;
    int total_cnt = 0;

    subneg_mem_responder #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .latch_clk(latch_clk), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .out_latch_clk(out_latch_clk), .out_value(out_value), .out_strobe(out_strobe),
        .bus_conflict(bus_conflict), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data)
    );

    subneg_mem_responder #(.DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out16), .bus_oe(bus_oe16),
        .latch_clk(latch_clk), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .out_latch_clk(out_latch_clk), .out_value(out_value16), .out_strobe(out_strobe16),
        .bus_conflict(bus_conflict16), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_preload(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_latch(input logic [7:0] a);
        bus_in = a; latch_clk = 1'b1;
        tick();
        latch_clk = 1'b0;
        tick();
    endtask

    task automatic read_mem(input logic [7:0] a, output logic [7:0] v, output logic [7:0] v16);
        do_latch(a);
        mem_oe_n = 1'b0;
        #1;
        v = bus_out; v16 = bus_out16;
        mem_oe_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_in = 8'h00; latch_clk = 1'b0; mem_oe_n = 1'b1; mem_we_n = 1'b1;
        out_latch_clk = 1'b0; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        tick(); tick();
        total_cnt++;
        if ({out_value, out_strobe, bus_conflict, bus_oe} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state got %h %b %b %b want 00 0 0 0", out_value, out_strobe, bus_conflict, bus_oe);
        end else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        do_preload(8'h10, 8'h5A);
        bus_in = 8'h10; latch_clk = 1'b1;
        tick();
        latch_clk = 1'b0; mem_oe_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus_oe, bus_out} !== {1'b1, 8'h5A}) begin
            $display("FAIL read_same_cycle got oe=%b data=%h want oe=1 data=5a", bus_oe, bus_out);
        end else pass_cnt++;
        mem_oe_n = 1'b1;
        #1;
        total_cnt++;
        if ({bus_oe, bus_out} !== {1'b0, 8'h5A}) begin
            $display("FAIL read_oe_off got oe=%b data=%h want oe=0 data=5a", bus_oe, bus_out);
        end else pass_cnt++;
        tick();
    endtask

    task automatic test_write();
        logic [7:0] v, v16;
        do_latch(8'h20);
        bus_in = 8'h33; mem_we_n = 1'b0;
        tick(); tick();
        mem_we_n = 1'b1; bus_in = 8'h99;
        tick();
        read_mem(8'h20, v, v16);
        total_cnt++;
        if (v !== 8'h33) $display("FAIL write_we_rise got %h want 33", v);
        else pass_cnt++;
    endtask

    task automatic test_out_latch();
        int strobes = 0;
        bus_in = 8'hC4; out_latch_clk = 1'b1;
        tick();
        total_cnt++;
        if ({out_value, out_strobe} !== {8'hC4, 1'b1}) begin
            $display("FAIL out_latch_first got %h %b want c4 1", out_value, out_strobe);
        end else pass_cnt++;
        if (out_strobe) strobes++;
        bus_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_strobe) strobes++;
        end
        out_latch_clk = 1'b0;
        tick();
        if (out_strobe) strobes++;
        total_cnt++;
        if ({strobes, out_value} !== {32'd1, 8'hC4}) begin
            $display("FAIL out_latch_hold got strobes=%0d value=%h want 1 c4", strobes, out_value);
        end else pass_cnt++;
    endtask

    task automatic test_conflict();
        logic [7:0] v, v16;
        do_preload(8'h05, 8'h11);
        do_latch(8'h05);
        mem_oe_n = 1'b0; mem_we_n = 1'b0; bus_in = 8'hEE;
        #1;
        total_cnt++;
        if (bus_oe !== 1'b1) $display("FAIL conflict_oe got %b want 1", bus_oe);
        else pass_cnt++;
        tick();
        mem_oe_n = 1'b1; mem_we_n = 1'b1;
        total_cnt++;
        if (bus_conflict !== 1'b1) $display("FAIL conflict_set got %b want 1", bus_conflict);
        else pass_cnt++;
        repeat (10) tick();
        total_cnt++;
        if (bus_conflict !== 1'b1) $display("FAIL conflict_sticky got %b want 1", bus_conflict);
        else pass_cnt++;
        read_mem(8'h05, v, v16);
        total_cnt++;
        if (v !== 8'h11) $display("FAIL conflict_no_write got %h want 11", v);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (bus_conflict !== 1'b0) $display("FAIL conflict_reset got %b want 0", bus_conflict);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_preload_collision();
        logic [7:0] v, v16;
        do_latch(8'h30);
        bus_in = 8'h55; mem_we_n = 1'b0;
        load_en = 1'b1; load_addr = 8'h30; load_data = 8'h66;
        tick();
        mem_we_n = 1'b1; load_en = 1'b0;
        read_mem(8'h30, v, v16);
        total_cnt++;
        if (v !== 8'h66) $display("FAIL preload_wins got %h want 66", v);
        else pass_cnt++;
        do_latch(8'h31);
        bus_in = 8'h77; mem_we_n = 1'b0;
        load_en = 1'b1; load_addr = 8'h32; load_data = 8'h88;
        tick();
        mem_we_n = 1'b1; load_en = 1'b0;
        read_mem(8'h31, v, v16);
        total_cnt++;
        if (v !== 8'h77) $display("FAIL both_bus_write got %h want 77", v);
        else pass_cnt++;
        read_mem(8'h32, v, v16);
        total_cnt++;
        if (v !== 8'h88) $display("FAIL both_preload got %h want 88", v);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_preload(8'h00, 8'hB0);
        do_preload(8'h40, 8'hA0);
        do_preload(8'h41, 8'hA1);
        do_latch(8'h40);
        mem_oe_n = 1'b0;
        #1;
        total_cnt++;
        if (bus_out !== 8'hA0) $display("FAIL mid_pre_latch got %h want a0", bus_out);
        else pass_cnt++;
        latch_clk = 1'b1; bus_in = 8'h41; reset = 1'b1;
        tick(); tick();
        total_cnt++;
        if (bus_out !== 8'hB0) $display("FAIL mid_during_reset got %h want b0", bus_out);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (bus_out !== 8'hA1) $display("FAIL mid_first_after got %h want a1", bus_out);
        else pass_cnt++;
        bus_in = 8'h40;
        tick();
        total_cnt++;
        if (bus_out !== 8'hA1) $display("FAIL mid_held_high got %h want a1", bus_out);
        else pass_cnt++;
        latch_clk = 1'b0; mem_oe_n = 1'b1;
        tick();
    endtask

    task automatic test_aliasing();
        logic [7:0] v, v16;
        do_preload(8'h03, 8'h12);
        do_latch(8'h13);
        bus_in = 8'h7E; mem_we_n = 1'b0;
        tick();
        mem_we_n = 1'b1;
        read_mem(8'h03, v, v16);
        total_cnt++;
        if (v16 !== 8'h7E) $display("FAIL alias16 got %h want 7e", v16);
        else pass_cnt++;
        total_cnt++;
        if (v !== 8'h12) $display("FAIL alias256_untouched got %h want 12", v);
        else pass_cnt++;
    endtask

    task automatic test_integration();
        logic [7:0] prog [3];
        logic [7:0] va, vb, v16, res;
        int strobes = 0;
        do_preload(8'h00, 8'h10);
        do_preload(8'h01, 8'hFF);
        do_preload(8'h02, 8'h00);
        do_preload(8'h10, 8'h02);
        do_preload(8'hFF, 8'h05);
        for (int i = 0; i < 3; i++) read_mem(8'(i), prog[i], v16);
        total_cnt++;
        if ({prog[0], prog[1], prog[2]} !== 24'h10FF00) begin
            $display("FAIL cpu_fetch got %h%h%h want 10ff00", prog[0], prog[1], prog[2]);
        end else pass_cnt++;
        read_mem(prog[0], va, v16);
        read_mem(prog[1], vb, v16);
        res = vb - va;
        bus_in = res; out_latch_clk = 1'b1;
        tick();
        if (out_strobe) strobes++;
        out_latch_clk = 1'b0; bus_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_strobe) strobes++;
        end
        total_cnt++;
        if ({out_value, strobes} !== {8'h03, 32'd1}) begin
            $display("FAIL cpu_output got value=%h strobes=%0d want 03 1", out_value, strobes);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_out_latch();
        test_conflict();
        test_preload_collision();
        test_reset_mid();
        test_aliasing();
        test_integration();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
